// File: rtl/led_driver_receiver_if.sv
// Serial link and decoded results of one LED driver receiver.
// The master side drives SCLK/LAT/SIN, and the slave side is the receiver.
// Optional macro LED_RX_SOUT_ECHO_EN adds the SOUT daisy-chain output.
interface led_driver_receiver_if #(
   parameter int SHIFT_WIDTH = 48,
   parameter int NB_GS_WORDS = 16
);
   logic                           SCLK;
   logic                           LAT;
   logic                           SIN;
   logic [SHIFT_WIDTH-1:0]         gs_word;
   logic [$clog2(NB_GS_WORDS)-1:0] gs_index;
   logic                           gs_valid;
   logic                           latgs;
   logic [SHIFT_WIDTH-1:0]         fc_data;
   logic                           fc_valid;
   logic                           cmd_error;
`ifdef LED_RX_SOUT_ECHO_EN
   logic                           SOUT;
`endif

   modport master (
      output SCLK, LAT, SIN,
      input  gs_word, gs_index, gs_valid, latgs, fc_data, fc_valid, cmd_error
`ifdef LED_RX_SOUT_ECHO_EN
      , SOUT
`endif
   );

   modport slave (
      input  SCLK, LAT, SIN,
      output gs_word, gs_index, gs_valid, latgs, fc_data, fc_valid, cmd_error
`ifdef LED_RX_SOUT_ECHO_EN
      , SOUT
`endif
   );
endinterface

// File: rtl/led_driver_receiver.sv
// Receiving end of the LED band serial link, modelling one LED driver chip.
// It shifts SIN on SCLK rises and counts the SCLK rises seen while LAT is high.
// On the LAT fall, it decodes that count into WRTGS/LATGS/WRTFC/FCWRTEN.
// Optional macro LED_RX_SOUT_ECHO_EN adds the SOUT echo of the shift register MSB.
module led_driver_receiver #(
   parameter int SHIFT_WIDTH   = 48,
   parameter int NB_GS_WORDS   = 16,
   parameter int LAT_CNT_WIDTH = 5
) (
   input logic                  clk,
   input logic                  rst,
   led_driver_receiver_if.slave bus
);
   localparam int IDX_W = $clog2(NB_GS_WORDS);

   localparam logic [LAT_CNT_WIDTH-1:0] CMD_NONE    = LAT_CNT_WIDTH'(0);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_WRTGS   = LAT_CNT_WIDTH'(1);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_LATGS   = LAT_CNT_WIDTH'(3);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_WRTFC   = LAT_CNT_WIDTH'(5);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_FCWRTEN = LAT_CNT_WIDTH'(15);

   typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DECODE} state_t;

   state_t                   state_reg, state_next;
   logic                     sclk_q_reg, lat_q_reg;
   logic                     lat_idle_reg;
   logic [SHIFT_WIDTH-1:0]   shift_data_reg;
   logic [LAT_CNT_WIDTH-1:0] lat_cnt_reg, lat_cnt_next;
   logic [SHIFT_WIDTH-1:0]   gs_word_reg, gs_word_next;
   logic [IDX_W-1:0]         gs_index_reg, gs_index_next;
   logic                     gs_valid_reg, gs_valid_next;
   logic                     latgs_reg, latgs_next;
   logic [SHIFT_WIDTH-1:0]   fc_data_reg, fc_data_next;
   logic                     fc_valid_reg, fc_valid_next;
   logic                     cmd_error_reg, cmd_error_next;
   logic                     fc_armed_reg, fc_armed_next;

   logic                     sclk_rise, lat_fall, lat_start;
   logic [LAT_CNT_WIDTH-1:0] lat_cnt_sat;

   assign sclk_rise   = bus.SCLK & ~sclk_q_reg;
   assign lat_fall    = ~bus.LAT & lat_q_reg;
   // LAT that is already high when reset releases belongs to an aborted command.
   // Such a LAT pulse is ignored until LAT has been seen low.
   assign lat_start   = bus.LAT & lat_idle_reg;
   assign lat_cnt_sat = (lat_cnt_reg == '1) ? lat_cnt_reg : lat_cnt_reg + 1'b1;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next state, command counter, decode and index stepping
   always_comb begin
      state_next     = state_reg;
      lat_cnt_next   = lat_cnt_reg;
      gs_word_next   = gs_word_reg;
      gs_index_next  = gs_index_reg;
      gs_valid_next  = 1'b0;
      latgs_next     = 1'b0;
      fc_data_next   = fc_data_reg;
      fc_valid_next  = fc_valid_reg;
      cmd_error_next = cmd_error_reg;
      fc_armed_next  = fc_armed_reg;

      // The slot stays visible during the pulse and advances one cycle later.
      if (gs_valid_reg)
         gs_index_next = latgs_reg ? '0 : gs_index_reg + 1'b1;

      case (state_reg)
         ST_COUNT: begin
            // An SCLK rise in the LAT-fall cycle still counts toward this command.
            if (sclk_rise) lat_cnt_next = lat_cnt_sat;
            if (lat_fall)  state_next   = ST_DECODE;
         end
         default: begin
            if (lat_start) begin
               state_next   = ST_COUNT;
               lat_cnt_next = sclk_rise ? LAT_CNT_WIDTH'(1) : '0;
            end else begin
               state_next   = ST_IDLE;
            end
         end
      endcase

      if (state_reg == ST_DECODE) begin
         case (lat_cnt_reg)
            CMD_NONE: begin
            end
            CMD_WRTGS: begin
               gs_word_next  = shift_data_reg;
               gs_valid_next = 1'b1;
               fc_armed_next = 1'b0;
            end
            CMD_LATGS: begin
               gs_word_next  = shift_data_reg;
               gs_valid_next = 1'b1;
               latgs_next    = 1'b1;
               fc_armed_next = 1'b0;
            end
            CMD_WRTFC: begin
               if (fc_armed_reg) begin
                  fc_data_next  = shift_data_reg;
                  fc_valid_next = 1'b1;
               end else begin
                  cmd_error_next = 1'b1;
               end
               fc_armed_next = 1'b0;
            end
            CMD_FCWRTEN: begin
               fc_armed_next = 1'b1;
            end
            default: begin
               cmd_error_next = 1'b1;
               fc_armed_next  = 1'b0;
            end
         endcase
      end
   end

   // Edge history, shift register and registered decode results
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q_reg     <= 1'b0;
         lat_q_reg      <= 1'b0;
         lat_idle_reg   <= 1'b0;
         shift_data_reg <= '0;
         lat_cnt_reg    <= '0;
         gs_word_reg    <= '0;
         gs_index_reg   <= '0;
         gs_valid_reg   <= 1'b0;
         latgs_reg      <= 1'b0;
         fc_data_reg    <= '0;
         fc_valid_reg   <= 1'b0;
         cmd_error_reg  <= 1'b0;
         fc_armed_reg   <= 1'b0;
      end else begin
         sclk_q_reg     <= bus.SCLK;
         lat_q_reg      <= bus.LAT;
         if (!bus.LAT) lat_idle_reg <= 1'b1;
         if (sclk_rise) shift_data_reg <= {shift_data_reg[SHIFT_WIDTH-2:0], bus.SIN};
         lat_cnt_reg    <= lat_cnt_next;
         gs_word_reg    <= gs_word_next;
         gs_index_reg   <= gs_index_next;
         gs_valid_reg   <= gs_valid_next;
         latgs_reg      <= latgs_next;
         fc_data_reg    <= fc_data_next;
         fc_valid_reg   <= fc_valid_next;
         cmd_error_reg  <= cmd_error_next;
         fc_armed_reg   <= fc_armed_next;
      end
   end

`ifdef LED_RX_SOUT_ECHO_EN
   logic sout_reg;

   // SOUT copies the MSB that the current SCLK rise produces.
   // A downstream chip therefore sees the same bit the MSB now holds.
   always_ff @(posedge clk) begin
      if (rst)            sout_reg <= 1'b0;
      else if (sclk_rise) sout_reg <= shift_data_reg[SHIFT_WIDTH-2];
   end

   assign bus.SOUT = sout_reg;
`endif

   assign bus.gs_word   = gs_word_reg;
   assign bus.gs_index  = gs_index_reg;
   assign bus.gs_valid  = gs_valid_reg;
   assign bus.latgs     = latgs_reg;
   assign bus.fc_data   = fc_data_reg;
   assign bus.fc_valid  = fc_valid_reg;
   assign bus.cmd_error = cmd_error_reg;
endmodule
